// File: rtl/raw_isp_pkg.sv
// Shared constants and Bayer encodings for the raw-domain ISP stages.
// Channel index is the 2-bit phase {line_parity, pixel_lsb} XORed with the pattern.
package raw_isp_pkg;

   localparam int RAW_BITS      = 8;
   localparam int RAW_WIDTH     = 1936;
   localparam int RAW_GAIN_FRAC = 6;

   typedef enum logic [1:0] {
      CH_R  = 2'd0,
      CH_GR = 2'd1,
      CH_GB = 2'd2,
      CH_B  = 2'd3
   } bayer_ch_e;

   typedef enum logic [1:0] {
      PAT_RGGB = 2'd0,
      PAT_GRBG = 2'd1,
      PAT_GBRG = 2'd2,
      PAT_BGGR = 2'd3
   } bayer_pat_e;

   function automatic bayer_ch_e channel_of(input logic [1:0] phase, input logic [1:0] pattern);
      return bayer_ch_e'(phase ^ pattern);
   endfunction

endpackage

// File: rtl/raw_bayer_phase.sv
// Tracks the Bayer phase of the incoming pixel: pixel counter, line parity and
// vsync rising-edge detect. Phase reflects the position of the pixel presented now.
module raw_bayer_phase
   import raw_isp_pkg::*;
#(
   parameter int WIDTH = RAW_WIDTH
) (
   input  logic       pclk,
   input  logic       rst,
   input  logic       per_raw_clken,
   input  logic       per_frame_vsync,
   output logic [1:0] phase,
   output logic       vsync_rise
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   logic [CW-1:0] cnt_reg;
   logic          parity_reg;
   logic          vsync_prev_reg;

   assign vsync_rise = per_frame_vsync & ~vsync_prev_reg;
   assign phase      = {parity_reg, cnt_reg[0]};

   always_ff @(posedge pclk) begin
      if (rst) begin
         cnt_reg        <= '0;
         parity_reg     <= 1'b0;
         vsync_prev_reg <= 1'b0;
      end else begin
         vsync_prev_reg <= per_frame_vsync;
         // Frame start wins over a pixel arriving in the same cycle.
         if (vsync_rise) begin
            cnt_reg    <= '0;
            parity_reg <= 1'b0;
         end else if (per_raw_clken) begin
            if (cnt_reg == CW'(WIDTH - 1)) begin
               cnt_reg    <= '0;
               parity_reg <= ~parity_reg;
            end else begin
               cnt_reg <= cnt_reg + CW'(1);
            end
         end
      end
   end

endmodule

// File: rtl/raw_blc_gain.sv
// Per-channel black-level subtraction and u2.6 gain on Bayer raw data, 4-stage
// pipeline; configuration is double-buffered and switches only at frame start.
module raw_blc_gain
   import raw_isp_pkg::*;
#(
   parameter int BITS      = RAW_BITS,
   parameter int WIDTH     = RAW_WIDTH,
   parameter int GAIN_FRAC = RAW_GAIN_FRAC
) (
   input  logic            pclk,
   input  logic            rst,
   input  logic [BITS-1:0] per_raw_data,
   input  logic            per_raw_clken,
   input  logic            per_frame_vsync,
   input  logic [BITS-1:0] cfg_blc_r,
   input  logic [BITS-1:0] cfg_blc_gr,
   input  logic [BITS-1:0] cfg_blc_gb,
   input  logic [BITS-1:0] cfg_blc_b,
   input  logic [7:0]      cfg_gain_r,
   input  logic [7:0]      cfg_gain_gr,
   input  logic [7:0]      cfg_gain_gb,
   input  logic [7:0]      cfg_gain_b,
   input  logic [1:0]      cfg_bayer_pattern,
   input  logic            cfg_valid,
   output logic [BITS-1:0] post_raw_data,
   output logic            post_raw_clken,
   output logic            post_frame_vsync
);

   localparam int             PW         = BITS + 8;
   localparam int             PW1        = PW + 1;
   localparam logic [7:0]     GAIN_ONE   = 8'(1 << GAIN_FRAC);
   localparam logic [PW:0]    ROUND_HALF = PW1'(1 << (GAIN_FRAC - 1));
   localparam logic [PW:0]    PIX_MAX    = PW1'((1 << BITS) - 1);

   logic [1:0]      phase;
   logic            vsync_rise;
   logic [BITS-1:0] cfg_blc_arr [4];
   logic [7:0]      cfg_gain_arr [4];
   logic [BITS-1:0] act_blc [4];
   logic [7:0]      act_gain [4];
   bayer_pat_e      pend_pat_reg, act_pat_reg;
   bayer_ch_e       ch;

   raw_bayer_phase #(.WIDTH(WIDTH)) u_phase (
      .pclk            (pclk),
      .rst             (rst),
      .per_raw_clken   (per_raw_clken),
      .per_frame_vsync (per_frame_vsync),
      .phase           (phase),
      .vsync_rise      (vsync_rise)
   );

   assign cfg_blc_arr[CH_R]   = cfg_blc_r;
   assign cfg_blc_arr[CH_GR]  = cfg_blc_gr;
   assign cfg_blc_arr[CH_GB]  = cfg_blc_gb;
   assign cfg_blc_arr[CH_B]   = cfg_blc_b;
   assign cfg_gain_arr[CH_R]  = cfg_gain_r;
   assign cfg_gain_arr[CH_GR] = cfg_gain_gr;
   assign cfg_gain_arr[CH_GB] = cfg_gain_gb;
   assign cfg_gain_arr[CH_B]  = cfg_gain_b;

   // A cfg_valid landing on the frame-start edge goes straight to the active set.
   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_ch
         logic [BITS-1:0] pend_blc_reg, act_blc_reg;
         logic [7:0]      pend_gain_reg, act_gain_reg;

         always_ff @(posedge pclk) begin
            if (rst) begin
               pend_blc_reg  <= '0;
               act_blc_reg   <= '0;
               pend_gain_reg <= GAIN_ONE;
               act_gain_reg  <= GAIN_ONE;
            end else begin
               if (cfg_valid) begin
                  pend_blc_reg  <= cfg_blc_arr[gi];
                  pend_gain_reg <= cfg_gain_arr[gi];
               end
               if (vsync_rise) begin
                  act_blc_reg  <= cfg_valid ? cfg_blc_arr[gi]  : pend_blc_reg;
                  act_gain_reg <= cfg_valid ? cfg_gain_arr[gi] : pend_gain_reg;
               end
            end
         end

         assign act_blc[gi]  = act_blc_reg;
         assign act_gain[gi] = act_gain_reg;
      end
   endgenerate

   always_ff @(posedge pclk) begin
      if (rst) begin
         pend_pat_reg <= PAT_RGGB;
         act_pat_reg  <= PAT_RGGB;
      end else begin
         if (cfg_valid)
            pend_pat_reg <= bayer_pat_e'(cfg_bayer_pattern);
         if (vsync_rise)
            act_pat_reg <= cfg_valid ? bayer_pat_e'(cfg_bayer_pattern) : pend_pat_reg;
      end
   end

   assign ch = channel_of(phase, act_pat_reg);

   logic [BITS-1:0] s1_data_reg, s1_blc_reg, s2_diff_reg, post_data_reg;
   logic [7:0]      s1_gain_reg, s2_gain_reg;
   logic [PW-1:0]   s3_prod_reg;
   logic [3:0]      clken_pipe_reg, vsync_pipe_reg;
   logic [PW:0]     rounded, scaled;

   assign rounded = {1'b0, s3_prod_reg} + ROUND_HALF;
   assign scaled  = rounded >> GAIN_FRAC;

   always_ff @(posedge pclk) begin
      if (rst) begin
         s1_data_reg    <= '0;
         s1_blc_reg     <= '0;
         s1_gain_reg    <= '0;
         s2_diff_reg    <= '0;
         s2_gain_reg    <= '0;
         s3_prod_reg    <= '0;
         post_data_reg  <= '0;
         clken_pipe_reg <= '0;
         vsync_pipe_reg <= '0;
      end else begin
         clken_pipe_reg <= {clken_pipe_reg[2:0], per_raw_clken};
         vsync_pipe_reg <= {vsync_pipe_reg[2:0], per_frame_vsync};
         s1_data_reg    <= per_raw_data;
         s1_blc_reg     <= act_blc[ch];
         s1_gain_reg    <= act_gain[ch];
         s2_diff_reg    <= (s1_data_reg > s1_blc_reg) ? (s1_data_reg - s1_blc_reg) : '0;
         s2_gain_reg    <= s1_gain_reg;
         s3_prod_reg    <= PW'(s2_diff_reg) * PW'(s2_gain_reg);
         // Output is forced to zero whenever the aligned valid is low.
         if (!clken_pipe_reg[2])
            post_data_reg <= '0;
         else if (scaled > PIX_MAX)
            post_data_reg <= '1;
         else
            post_data_reg <= scaled[BITS-1:0];
      end
   end

   assign post_raw_data    = post_data_reg;
   assign post_raw_clken   = clken_pipe_reg[3];
   assign post_frame_vsync = vsync_pipe_reg[3];

endmodule

// File: tb/tb_raw_blc_gain.sv
// Bench for raw_blc_gain: directed vector table, multi-cycle corner sequences and
// random traffic, all checked cycle-by-cycle against a frame-position reference model.
module tb_raw_blc_gain;

   localparam int W = 1936;

   logic       pclk = 1'b0;
   logic       rst;
   logic [7:0] per_raw_data;
   logic       per_raw_clken, per_frame_vsync, cfg_valid;
   logic [7:0] c_blc [4];
   logic [7:0] c_gain [4];
   logic [1:0] c_pat;
   logic [7:0] post_raw_data;
   logic       post_raw_clken, post_frame_vsync;

   always #5 pclk = ~pclk;

   raw_blc_gain dut (
      .pclk              (pclk),
      .rst               (rst),
      .per_raw_data      (per_raw_data),
      .per_raw_clken     (per_raw_clken),
      .per_frame_vsync   (per_frame_vsync),
      .cfg_blc_r         (c_blc[0]),
      .cfg_blc_gr        (c_blc[1]),
      .cfg_blc_gb        (c_blc[2]),
      .cfg_blc_b         (c_blc[3]),
      .cfg_gain_r        (c_gain[0]),
      .cfg_gain_gr       (c_gain[1]),
      .cfg_gain_gb       (c_gain[2]),
      .cfg_gain_b        (c_gain[3]),
      .cfg_bayer_pattern (c_pat),
      .cfg_valid         (cfg_valid),
      .post_raw_data     (post_raw_data),
      .post_raw_clken    (post_raw_clken),
      .post_frame_vsync  (post_frame_vsync)
   );

   typedef struct {
      bit ck;
      bit vs;
      int d;
   } exp_t;

   typedef struct {
      int pix;
      int blc;
      int gain;
      int expv;
   } vec_t;

   int   n_checks = 0;
   int   n_fail   = 0;
   int   cyc      = 0;
   exp_t expq[$];
   bit   last_ck;
   int   last_d;

   // Reference model state: configuration sets and pixel index within the frame.
   int m_pend_blc[4], m_pend_gain[4], m_pend_pat;
   int m_act_blc[4],  m_act_gain[4],  m_act_pat;
   int m_pix;
   bit m_prev_vs;

   function automatic int ref_pixel(input int d, input int blc, input int gain);
      int v;
      v = d - blc;
      if (v < 0) v = 0;
      v = (v * gain + 32) / 64;
      if (v > 255) v = 255;
      return v;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 4; i++) begin
         m_pend_blc[i] = 0; m_pend_gain[i] = 64;
         m_act_blc[i]  = 0; m_act_gain[i]  = 64;
      end
      m_pend_pat = 0; m_act_pat = 0; m_pix = 0; m_prev_vs = 0;
   endtask

   task automatic step(input bit ck, input int d, input bit vs, input bit cv);
      exp_t e, got;
      int   ch;
      bit   rise;
      per_raw_clken   = ck;
      per_raw_data    = d[7:0];
      per_frame_vsync = vs;
      cfg_valid       = cv;
      e.ck = ck; e.vs = vs; e.d = 0;
      if (ck) begin
         ch  = ((((m_pix / W) % 2) << 1) | (m_pix % 2)) ^ m_act_pat;
         e.d = ref_pixel(d, m_act_blc[ch], m_act_gain[ch]);
      end
      rise = vs && !m_prev_vs;
      m_prev_vs = vs;
      if (rise) begin
         m_pix = 0;
         for (int i = 0; i < 4; i++) begin
            m_act_blc[i]  = cv ? int'(c_blc[i])  : m_pend_blc[i];
            m_act_gain[i] = cv ? int'(c_gain[i]) : m_pend_gain[i];
         end
         m_act_pat = cv ? int'(c_pat) : m_pend_pat;
      end else if (ck) begin
         m_pix++;
      end
      if (cv) begin
         for (int i = 0; i < 4; i++) begin
            m_pend_blc[i] = c_blc[i]; m_pend_gain[i] = c_gain[i];
         end
         m_pend_pat = c_pat;
      end
      expq.push_back(e);
      @(posedge pclk); #1;
      cyc++;
      last_ck = post_raw_clken;
      last_d  = post_raw_data;
      if (expq.size() >= 4) begin
         got = expq.pop_front();
         n_checks++;
         if (post_raw_clken !== got.ck || post_frame_vsync !== got.vs || int'(post_raw_data) != got.d) begin
            n_fail++;
            $display("FAIL pipe cycle %0d: got clken=%0b vsync=%0b data=%0d, want clken=%0b vsync=%0b data=%0d",
                     cyc, post_raw_clken, post_frame_vsync, post_raw_data, got.ck, got.vs, got.d);
         end
      end
   endtask

   task automatic do_reset(input int n);
      exp_t z;
      rst = 1'b1; per_raw_clken = 1'b0; per_frame_vsync = 1'b0; cfg_valid = 1'b0; per_raw_data = '0;
      repeat (n) begin
         @(posedge pclk); #1;
         cyc++;
         n_checks++;
         if (post_raw_clken !== 1'b0 || post_raw_data !== 8'd0 || post_frame_vsync !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs cycle %0d: got clken=%0b data=%0d vsync=%0b, want all 0",
                     cyc, post_raw_clken, post_raw_data, post_frame_vsync);
         end
      end
      model_reset();
      expq.delete();
      z.ck = 0; z.vs = 0; z.d = 0;
      repeat (3) expq.push_back(z);
      rst = 1'b0;
   endtask

   task automatic set_cfg(input int b0, input int b1, input int b2, input int b3,
                          input int g0, input int g1, input int g2, input int g3, input int pat);
      c_blc[0] = b0[7:0]; c_blc[1] = b1[7:0]; c_blc[2] = b2[7:0]; c_blc[3] = b3[7:0];
      c_gain[0] = g0[7:0]; c_gain[1] = g1[7:0]; c_gain[2] = g2[7:0]; c_gain[3] = g3[7:0];
      c_pat = pat[1:0];
      step(0, 0, 0, 1);
   endtask

   task automatic frame_start();
      step(0, 0, 1, 0);
      step(0, 0, 0, 0);
   endtask

   // Sends one pixel and checks it emerges exactly 4 cycles later with the given value.
   task automatic pixel_check(input string name, input int d, input int expv);
      step(1, d, 0, 0);
      repeat (3) step(0, 0, 0, 0);
      n_checks++;
      if (!(last_ck === 1'b1 && last_d == expv)) begin
         n_fail++;
         $display("FAIL %s: got clken=%0b data=%0d, want clken=1 data=%0d", name, last_ck, last_d, expv);
      end
   endtask

   vec_t vecs[9];

   initial begin
      vecs[0] = '{100, 16,  64,  84};
      vecs[1] = '{ 10, 16,  64,   0};
      vecs[2] = '{200,  0, 128, 255};
      vecs[3] = '{  3,  0,  96,   5};
      vecs[4] = '{255,  0, 255, 255};
      vecs[5] = '{ 51, 50,  64,   1};
      vecs[6] = '{ 50, 50,  64,   0};
      vecs[7] = '{  1,  0,  32,   1};
      vecs[8] = '{  1,  0,  31,   0};

      for (int i = 0; i < 4; i++) begin c_blc[i] = '0; c_gain[i] = 8'd64; end
      c_pat = '0;
      do_reset(3);

      // Directed single-pixel vectors at the first pixel of a frame.
      for (int i = 0; i < 9; i++) begin
         set_cfg(vecs[i].blc, vecs[i].blc, vecs[i].blc, vecs[i].blc,
                 vecs[i].gain, vecs[i].gain, vecs[i].gain, vecs[i].gain, 0);
         frame_start();
         pixel_check($sformatf("vec%0d", i), vecs[i].pix, vecs[i].expv);
      end

      // Mid-frame gain change must wait for the next frame start.
      set_cfg(0, 0, 0, 0, 64, 64, 64, 64, 0);
      frame_start();
      step(1, 100, 0, 0);
      pixel_check("gr_base", 100, 100);
      c_gain[1] = 8'd128;
      step(0, 0, 0, 1);
      step(1, 100, 0, 0);
      pixel_check("gr_midframe", 100, 100);
      frame_start();
      step(1, 100, 0, 0);
      pixel_check("gr_next_frame", 100, 200);

      // Line wrap after a full back-to-back line, for every pattern.
      for (int p = 0; p < 4; p++) begin
         set_cfg(1, 2, 3, 4, 64, 64, 64, 64, p);
         frame_start();
         for (int i = 0; i < W; i++) step(1, 100, 0, 0);
         pixel_check($sformatf("pat%0d_line1_px0", p), 100, 100 - ((2 ^ p) + 1));
         pixel_check($sformatf("pat%0d_line1_px1", p), 100, 100 - ((3 ^ p) + 1));
      end

      // One-cycle reset mid-line discards in-flight pixels and restores unity.
      set_cfg(30, 30, 30, 30, 128, 128, 128, 128, 0);
      frame_start();
      repeat (5) step(1, 50, 0, 0);
      do_reset(1);
      pixel_check("post_reset_unity", 77, 77);
      step(1, 90, 0, 0);

      // Gapped clken and vsync alignment.
      set_cfg(5, 6, 7, 8, 64, 80, 96, 112, 3);
      step(1, 40, 1, 0);
      step(0, 41, 1, 0);
      step(1, 42, 1, 0);
      step(1, 43, 0, 0);
      step(0, 44, 0, 0);
      repeat (4) step(0, 0, 0, 0);

      // Random traffic, including cfg updates that may coincide with frame start.
      for (int i = 0; i < 3000; i++) begin
         bit ck, vs, cv;
         ck = ($urandom_range(0, 3) != 0);
         vs = ((i % 400) < 3);
         cv = ($urandom_range(0, 39) == 0);
         if (cv) begin
            for (int k = 0; k < 4; k++) begin
               c_blc[k]  = 8'($urandom_range(0, 80));
               c_gain[k] = 8'($urandom_range(0, 255));
            end
            c_pat = 2'($urandom_range(0, 3));
         end
         step(ck, int'($urandom_range(0, 255)), vs, cv);
      end
      repeat (4) step(0, 0, 0, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL timeout: simulation exceeded time limit at cycle %0d", cyc);
      $fatal(1, "timeout");
   end

endmodule
